// File: rtl/gpio_bank_regs.sv
// GPIO register bank: per-pin output data, direction, open-drain and edge-event
// registers behind a simple strobe bus. Pad inputs are synchronised, and each
// pin can capture rising/falling edges into write-1-to-clear status bits. The
// interrupt output is high while any status bit is set.
module gpio_bank_regs #(
  parameter int                   AddrWidth = 16,
  parameter int                   BusWidth  = 32,
  parameter int                   NumPins   = 72,
  parameter int                   RegWidth  = 24,
  parameter logic [AddrWidth-1:0] BaseAddr  = 16'h1000,
  parameter int                   NumRegs   = (NumPins + RegWidth - 1) / RegWidth
) (
  input  logic                   reg_clk,
  input  logic                   reset_in,
  input  logic                   chip_sel,
  input  logic                   write_reg,
  input  logic                   read_reg,
  input  logic [AddrWidth-1:2]   busaddress,
  input  logic [BusWidth-1:0]    busdata_in,
  output logic [BusWidth-1:0]    busdata_to_cpu,
  output logic                   read_valid,
  input  logic [NumPins-1:0]     pin_in,
  output logic [NumPins-1:0]     pin_out,
  output logic [NumPins-1:0]     pin_oe,
  output logic                   irq
);

  // Register class selected by byte offset bits [11:8] within the bank.
  localparam logic [3:0] ClsData   = 4'd0;
  localparam logic [3:0] ClsDdr    = 4'd1;
  localparam logic [3:0] ClsOd     = 4'd3;
  localparam logic [3:0] ClsRise   = 4'd4;
  localparam logic [3:0] ClsFall   = 4'd5;
  localparam logic [3:0] ClsStatus = 4'd6;

  logic [AddrWidth-1:0] byte_addr;
  logic [AddrWidth-1:0] offset;
  logic                 in_bank;
  logic [3:0]           reg_cls;
  logic [5:0]           word_idx;
  logic                 wr_acc;
  logic                 rd_acc;

  // Pin-indexed register state.
  logic [NumPins-1:0] data_reg;
  logic [NumPins-1:0] ddr_reg;
  logic [NumPins-1:0] od_reg;
  logic [NumPins-1:0] rise_en_reg;
  logic [NumPins-1:0] fall_en_reg;
  logic [NumPins-1:0] status_reg;

  // Input path: sync_p0/sync_p1 form the synchroniser, sync_p2 holds the
  // previous synchronised value for edge detection.
  logic [NumPins-1:0] sync_p0;
  logic [NumPins-1:0] sync_p1;
  logic [NumPins-1:0] sync_p2;

  logic [NumPins-1:0] rise_evt;
  logic [NumPins-1:0] fall_evt;
  logic [NumPins-1:0] cls_vec;
  logic [BusWidth-1:0] rd_word;
  logic [NumPins-1:0] wr_sel;
  logic [NumPins-1:0] wr_val;
  logic [NumPins-1:0] wr_data_en;
  logic [NumPins-1:0] wr_ddr_en;
  logic [NumPins-1:0] wr_od_en;
  logic [NumPins-1:0] wr_rise_en;
  logic [NumPins-1:0] wr_fall_en;
  logic [NumPins-1:0] status_clr;

  // Bank decode assumes AddrWidth >= 12 so the class/word fields exist.
  assign byte_addr = {busaddress, 2'b00};
  assign offset    = byte_addr - BaseAddr;
  assign in_bank   = (byte_addr >= BaseAddr) && (offset < AddrWidth'(12'h700));
  assign reg_cls   = offset[11:8];
  assign word_idx  = offset[7:2];
  assign wr_acc    = chip_sel & write_reg;
  assign rd_acc    = chip_sel & read_reg;

  assign rise_evt = sync_p1 & ~sync_p2 & rise_en_reg;
  assign fall_evt = ~sync_p1 & sync_p2 & fall_en_reg;

  if (RegWidth < BusWidth) begin : g_unused_hi
    // Data bits above the register width are never stored.
    logic unused_hi;
    assign unused_hi = ^busdata_in[BusWidth-1:RegWidth];
  end

  // Select the pin vector backing the addressed register class.
  always_comb begin
    cls_vec = '0;
    case (reg_cls)
      ClsData:   cls_vec = sync_p1;
      ClsDdr:    cls_vec = ddr_reg;
      ClsOd:     cls_vec = od_reg;
      ClsRise:   cls_vec = rise_en_reg;
      ClsFall:   cls_vec = fall_en_reg;
      ClsStatus: cls_vec = status_reg;
      default:   cls_vec = '0;
    endcase
  end

  // Gather the pins of the addressed word; missing pins and high bits read 0.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NumPins; p++) begin
      if (in_bank && (int'(word_idx) == p / RegWidth))
        rd_word[p % RegWidth] = cls_vec[p];
    end
  end

  // Spread the write word onto the pins it covers.
  always_comb begin
    wr_sel = '0;
    wr_val = '0;
    for (int p = 0; p < NumPins; p++) begin
      wr_sel[p] = wr_acc && in_bank && (int'(word_idx) == p / RegWidth);
      wr_val[p] = busdata_in[p % RegWidth];
    end
  end

  assign wr_data_en = wr_sel & {NumPins{reg_cls == ClsData}};
  assign wr_ddr_en  = wr_sel & {NumPins{reg_cls == ClsDdr}};
  assign wr_od_en   = wr_sel & {NumPins{reg_cls == ClsOd}};
  assign wr_rise_en = wr_sel & {NumPins{reg_cls == ClsRise}};
  assign wr_fall_en = wr_sel & {NumPins{reg_cls == ClsFall}};
  assign status_clr = wr_sel & {NumPins{reg_cls == ClsStatus}} & wr_val;

  // Configuration registers: masked per-pin update on accepted writes.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      data_reg    <= '0;
      ddr_reg     <= '0;
      od_reg      <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
    end else begin
      data_reg    <= (data_reg    & ~wr_data_en) | (wr_val & wr_data_en);
      ddr_reg     <= (ddr_reg     & ~wr_ddr_en)  | (wr_val & wr_ddr_en);
      od_reg      <= (od_reg      & ~wr_od_en)   | (wr_val & wr_od_en);
      rise_en_reg <= (rise_en_reg & ~wr_rise_en) | (wr_val & wr_rise_en);
      fall_en_reg <= (fall_en_reg & ~wr_fall_en) | (wr_val & wr_fall_en);
    end
  end

  // Synchronise pads and keep the previous value for edge detection.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= pin_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Event status: W1C clear is applied first so a same-cycle event wins.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      status_reg <= '0;
      irq        <= 1'b0;
    end else begin
      status_reg <= (status_reg & ~status_clr) | rise_evt | fall_evt;
      irq        <= |status_reg;
    end
  end

  // Pad drive: open-drain pins only ever pull low, driving when DATA is 0.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      pin_out <= '0;
      pin_oe  <= '0;
    end else begin
      pin_out <= data_reg & ~od_reg;
      pin_oe  <= (od_reg & ~data_reg) | (~od_reg & ddr_reg);
    end
  end

  // Read response: registered data with a one-cycle valid pulse.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      busdata_to_cpu <= '0;
      read_valid     <= 1'b0;
    end else begin
      read_valid <= rd_acc;
      if (rd_acc)
        busdata_to_cpu <= rd_word;
    end
  end

endmodule

// File: tb/tb_gpio_bank_regs.sv
// Testbench for gpio_bank_regs: directed scenarios plus a randomized run,
// all compared against a pin-level behavioural model of the register bank.
module tb_gpio_bank_regs;

  localparam int NP = 72;
  localparam int RW = 24;
  localparam int NR = 3;

  logic          reg_clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          cs = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [13:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   busdata_to_cpu;
  logic          read_valid;
  logic [NP-1:0] pin = '0;
  logic [NP-1:0] pin_out;
  logic [NP-1:0] pin_oe;
  logic          irq;

  int errors = 0;
  int checks = 0;

  // Model state, indexed by pin number.
  logic [NP-1:0] m_data, m_ddr, m_od, m_rise, m_fall, m_status;
  // Pad values sampled at the last three edges (h1 newest).
  logic [NP-1:0] h1, h2, h3;
  logic [NP-1:0] exp_out, exp_oe;
  logic          exp_irq, exp_rv;
  logic [31:0]   exp_rd;

  gpio_bank_regs dut (
    .reg_clk        (reg_clk),
    .reset_in       (reset_in),
    .chip_sel       (cs),
    .write_reg      (wr),
    .read_reg       (rd),
    .busaddress     (addr),
    .busdata_in     (wdata),
    .busdata_to_cpu (busdata_to_cpu),
    .read_valid     (read_valid),
    .pin_in         (pin),
    .pin_out        (pin_out),
    .pin_oe         (pin_oe),
    .irq            (irq)
  );

  always #5 reg_clk = ~reg_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_data = '0; m_ddr = '0; m_od = '0; m_rise = '0; m_fall = '0; m_status = '0;
    h1 = '0; h2 = '0; h3 = '0;
    exp_out = '0; exp_oe = '0; exp_irq = 1'b0; exp_rv = 1'b0; exp_rd = '0;
  endtask

  // Decode a word address into register class and word index; -1 if unmapped.
  function automatic int m_decode(input logic [13:0] a, output int idx);
    int b;
    int off;
    int cls;
    b = int'(a) * 4;
    idx = 0;
    if (b < 'h1000 || b >= 'h1700) return -1;
    off = b - 'h1000;
    cls = off / 256;
    idx = (off % 256) / 4;
    if (idx >= NR || cls == 2) return -1;
    return cls;
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    int idx;
    int cls;
    logic [NP-1:0] v;
    logic [31:0] r;
    r = '0;
    cls = m_decode(a, idx);
    case (cls)
      0: v = h2;
      1: v = m_ddr;
      3: v = m_od;
      4: v = m_rise;
      5: v = m_fall;
      6: v = m_status;
      default: return '0;
    endcase
    for (int b = 0; b < RW; b++)
      if (idx * RW + b < NP) r[b] = v[idx * RW + b];
    return r;
  endfunction

  task automatic m_write(input logic [13:0] a, input logic [31:0] d);
    int idx;
    int cls;
    int p;
    cls = m_decode(a, idx);
    for (int b = 0; b < RW; b++) begin
      p = idx * RW + b;
      if (cls >= 0 && p < NP) begin
        case (cls)
          0: m_data[p] = d[b];
          1: m_ddr[p] = d[b];
          3: m_od[p] = d[b];
          4: m_rise[p] = d[b];
          5: m_fall[p] = d[b];
          6: if (d[b]) m_status[p] = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    logic [NP-1:0] ev;
    ev = (h2 & ~h3 & m_rise) | (~h2 & h3 & m_fall);
    for (int p = 0; p < NP; p++) begin
      exp_out[p] = m_od[p] ? 1'b0 : m_data[p];
      exp_oe[p]  = m_od[p] ? ~m_data[p] : m_ddr[p];
    end
    exp_irq = (m_status != '0);
    exp_rv  = cs & rd;
    if (cs && rd) exp_rd = m_read(addr);
    if (cs && wr) m_write(addr, wdata);
    m_status = m_status | ev;
    h3 = h2; h2 = h1; h1 = pin;
  endtask

  task automatic step();
    model_step();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic do_acc(input bit w, input bit r, input logic [15:0] byte_a, input logic [31:0] d);
    cs = 1'b1; wr = w; rd = r; addr = byte_a[15:2]; wdata = d;
    step();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    model_reset();
    repeat (3) @(posedge reg_clk);
    #1;
    checks++; if (pin_out !== '0) begin errors++; $display("FAIL reset pin_out got %h exp 0", pin_out); end
    checks++; if (pin_oe !== '0) begin errors++; $display("FAIL reset pin_oe got %h exp 0", pin_oe); end
    checks++; if (irq !== 1'b0 || read_valid !== 1'b0) begin errors++; $display("FAIL reset irq/read_valid got %b/%b exp 0/0", irq, read_valid); end
    checks++; if (busdata_to_cpu !== '0) begin errors++; $display("FAIL reset busdata got %h exp 0", busdata_to_cpu); end
    reset_in = 1'b0;
    do_acc(1'b0, 1'b1, 16'h1600, 32'h0);
    checks++; if (read_valid !== 1'b1 || busdata_to_cpu !== 32'h0) begin errors++; $display("FAIL reset status0 read got %b/%h exp 1/0", read_valid, busdata_to_cpu); end
  endtask

  task automatic test_ddr_data();
    do_acc(1'b1, 1'b0, 16'h1100, 32'h00A5A5A5);
    do_acc(1'b1, 1'b0, 16'h1000, 32'h00FFFFFF);
    checks++; if (pin_oe[23:0] !== 24'hA5A5A5) begin errors++; $display("FAIL ddr pin_oe got %h exp a5a5a5", pin_oe[23:0]); end
    do_acc(1'b0, 1'b1, 16'h1100, 32'h0);
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL ddr read_valid got %b exp 1", read_valid); end
    checks++; if (busdata_to_cpu !== 32'h00A5A5A5) begin errors++; $display("FAIL ddr readback got %h exp 00a5a5a5", busdata_to_cpu); end
    checks++; if (pin_out[23:0] !== 24'hFFFFFF) begin errors++; $display("FAIL data pin_out got %h exp ffffff", pin_out[23:0]); end
    step();
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL ddr read_valid pulse width got %b exp 0", read_valid); end
  endtask

  task automatic test_open_drain();
    do_acc(1'b1, 1'b0, 16'h1300, 32'h00000001);
    step();
    checks++; if (pin_out[0] !== 1'b0 || pin_oe[0] !== 1'b0) begin errors++; $display("FAIL od data1 got out/oe %b/%b exp 0/0", pin_out[0], pin_oe[0]); end
    do_acc(1'b1, 1'b0, 16'h1000, 32'h00FFFFFE);
    step();
    checks++; if (pin_out[0] !== 1'b0 || pin_oe[0] !== 1'b1) begin errors++; $display("FAIL od data0 got out/oe %b/%b exp 0/1", pin_out[0], pin_oe[0]); end
    do_acc(1'b1, 1'b0, 16'h1000, 32'h00FFFFFF);
    step();
    checks++; if (pin_out[0] !== 1'b0 || pin_oe[0] !== 1'b0) begin errors++; $display("FAIL od release got out/oe %b/%b exp 0/0", pin_out[0], pin_oe[0]); end
    checks++; if (pin_oe[1] !== 1'b0 || pin_oe[2] !== 1'b1) begin errors++; $display("FAIL od neighbours oe got %b%b exp 10", pin_oe[2], pin_oe[1]); end
  endtask

  task automatic test_rise_event();
    do_acc(1'b1, 1'b0, 16'h1404, 32'h00000010);
    pin[28] = 1'b1;
    step();
    step();
    do_acc(1'b0, 1'b1, 16'h1604, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL rise early status/irq got %h/%b exp 0/0", busdata_to_cpu, irq); end
    do_acc(1'b0, 1'b1, 16'h1604, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h10) begin errors++; $display("FAIL rise status1 got %h exp 10", busdata_to_cpu); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise irq got %b exp 1", irq); end
    do_acc(1'b1, 1'b0, 16'h1604, 32'h00000010);
    do_acc(1'b0, 1'b1, 16'h1604, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL w1c status/irq got %h/%b exp 0/0", busdata_to_cpu, irq); end
  endtask

  task automatic test_w1c_collision();
    pin[28] = 1'b0; repeat (3) step();
    pin[28] = 1'b1; repeat (3) step();
    pin[28] = 1'b0; repeat (3) step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide pre irq got %b exp 1", irq); end
    pin[28] = 1'b1;
    step();
    step();
    do_acc(1'b1, 1'b0, 16'h1604, 32'h00000010);
    do_acc(1'b0, 1'b1, 16'h1604, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h10) begin errors++; $display("FAIL collide status1 got %h exp 10", busdata_to_cpu); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide irq got %b exp 1", irq); end
  endtask

  task automatic test_upper_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    pin = r[NP-1:0];
    repeat (3) step();
    do_acc(1'b1, 1'b0, 16'h1008, 32'hFFFFFFFF);
    do_acc(1'b0, 1'b1, 16'h1008, 32'h0);
    checks++; if (busdata_to_cpu !== {8'h00, pin[71:48]}) begin errors++; $display("FAIL data2 read got %h exp %h", busdata_to_cpu, {8'h00, pin[71:48]}); end
    checks++; if (pin_out[71:48] !== 24'hFFFFFF) begin errors++; $display("FAIL data2 pin_out got %h exp ffffff", pin_out[71:48]); end
    do_acc(1'b0, 1'b1, 16'h1108, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h0) begin errors++; $display("FAIL ddr2 read got %h exp 0", busdata_to_cpu); end
    do_acc(1'b0, 1'b1, 16'h1700, 32'h0);
    checks++; if (read_valid !== 1'b1 || busdata_to_cpu !== 32'h0) begin errors++; $display("FAIL unmapped 700 got %b/%h exp 1/0", read_valid, busdata_to_cpu); end
    do_acc(1'b0, 1'b1, 16'h100C, 32'h0);
    checks++; if (read_valid !== 1'b1 || busdata_to_cpu !== 32'h0) begin errors++; $display("FAIL unmapped word3 got %b/%h exp 1/0", read_valid, busdata_to_cpu); end
  endtask

  task automatic test_random();
    logic [95:0] r1, r2;
    int cls;
    for (int c = 0; c < 800; c++) begin
      cs = ($urandom_range(0, 9) != 0);
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      cls = $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) addr = 14'($urandom);
      else addr = 14'((32'h1000 + cls * 256 + $urandom_range(0, 3) * 4) >> 2);
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        r1 = {$urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom};
        pin = pin ^ (r1[NP-1:0] & r2[NP-1:0]);
      end
      step();
      checks++; if (pin_out !== exp_out) begin errors++; $display("FAIL rnd pin_out cyc %0d got %h exp %h", c, pin_out, exp_out); end
      checks++; if (pin_oe !== exp_oe) begin errors++; $display("FAIL rnd pin_oe cyc %0d got %h exp %h", c, pin_oe, exp_oe); end
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL rnd irq cyc %0d got %b exp %b", c, irq, exp_irq); end
      checks++; if (read_valid !== exp_rv) begin errors++; $display("FAIL rnd read_valid cyc %0d got %b exp %b", c, read_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (busdata_to_cpu !== exp_rd) begin errors++; $display("FAIL rnd rdata cyc %0d addr %h got %h exp %h", c, addr, busdata_to_cpu, exp_rd); end
      end
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_acc(1'b1, 1'b0, 16'h1100, 32'h00A5A5A5);
    do_acc(1'b1, 1'b0, 16'h1400, 32'h00FFFFFF);
    do_acc(1'b1, 1'b0, 16'h1500, 32'h00FFFFFF);
    pin[23:0] = ~pin[23:0];
    repeat (4) step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid pre irq got %b exp 1", irq); end
    cs = 1'b1; rd = 1'b1; addr = 14'(16'h1100 >> 2);
    #2;
    reset_in = 1'b1;
    #1;
    checks++; if (pin_oe !== '0 || pin_out !== '0) begin errors++; $display("FAIL rstmid pads got oe %h out %h exp 0", pin_oe, pin_out); end
    checks++; if (irq !== 1'b0 || read_valid !== 1'b0) begin errors++; $display("FAIL rstmid irq/read_valid got %b/%b exp 0/0", irq, read_valid); end
    @(posedge reg_clk);
    #1;
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL rstmid read_valid pulsed got %b exp 0", read_valid); end
    cs = 1'b0; rd = 1'b0;
    model_reset();
    reset_in = 1'b0;
    do_acc(1'b0, 1'b1, 16'h1100, 32'h0);
    checks++; if (read_valid !== 1'b1 || busdata_to_cpu !== 32'h0) begin errors++; $display("FAIL rstmid ddr0 got %b/%h exp 1/0", read_valid, busdata_to_cpu); end
    do_acc(1'b0, 1'b1, 16'h1600, 32'h0);
    checks++; if (busdata_to_cpu !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL rstmid status0/irq got %h/%b exp 0/0", busdata_to_cpu, irq); end
  endtask

  initial begin
    test_reset();
    test_ddr_data();
    test_open_drain();
    test_rise_event();
    test_w1c_collision();
    test_upper_word();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bank_regs.md
Name: gpio_bank_regs

Overview:
Parametrised GPIO register bank for the HM3 bus. It generalises the fixed two-connector I/O, DDR and open-drain register set to any pin count. It adds input synchronisation, per-pin rising/falling edge capture, write-1-to-clear event status and a level interrupt output. It sits behind the address decoder on the reg_clk bus and drives the connector tri-state buffers through separate out/oe vectors.

Parameters:
AddrWidth, 16, byte address width of busaddress.
BusWidth, 32, bus data width.
NumPins, 72, GPIO pins handled by this bank (1..BusWidth*16).
RegWidth, 24, pins per register word (<= BusWidth).
BaseAddr, 16'h1000, byte base address of the bank.
NumRegs, (NumPins+RegWidth-1)/RegWidth, derived; words per register class.

Ports:
reg_clk  in  1  bus/register clock; all state on rising edge.
reset_in  in  1  asynchronous, active-high reset.
chip_sel  in  1  qualifies read_reg/write_reg.
write_reg  in  1  single-cycle write strobe.
read_reg  in  1  single-cycle read strobe.
busaddress  in  AddrWidth-2 (bits [AddrWidth-1:2])  word address.
busdata_in  in  BusWidth  write data.
busdata_to_cpu  out  BusWidth  read data, registered.
read_valid  out  1  one-cycle pulse; busdata_to_cpu valid.
pin_in  in  NumPins  raw pad inputs (asynchronous).
pin_out  out  NumPins  pad output value.
pin_oe  out  NumPins  pad output enable, 1 = drive.
irq  out  1  level interrupt; OR of enabled status bits.

Behaviour:
- Reset only via reset_in; single clock reg_clk. Reset clears all registers, sync flops, status, busdata_to_cpu, read_valid, irq, pin_out and pin_oe to 0.
- Register map, word i = 0..NumRegs-1, byte offset from BaseAddr:
  - +0x000+4i DATA: write sets output value; read returns synchronised pin input.
  - +0x100+4i DDR: 1 = output.
  - +0x300+4i OD: 1 = open drain.
  - +0x400+4i RISE_EN.
  - +0x500+4i FALL_EN.
  - +0x600+4i STATUS: read returns event bits; a write of 1 clears a bit (W1C).
- Pin p maps to word p/RegWidth, bit p%RegWidth.
- Read-back bits >= RegWidth and bits for pins >= NumPins return 0. Writes to those bits are ignored.
- Access is accepted when chip_sel=1 at a rising edge with the strobe high. Simultaneous read_reg and write_reg: both are performed; the read returns the pre-write value.
- Write latency: the register updates at the accepting edge; pin_out/pin_oe change at the following edge (registered outputs).
- Pad drive per pin:
  - OD=1: pin_out=0, pin_oe=~DATA (DDR ignored).
  - OD=0: pin_out=DATA, pin_oe=DDR.
- Read latency: busdata_to_cpu and read_valid are registered at the accepting edge and visible the next cycle. read_valid is high exactly one cycle. An unmapped address returns 0 with read_valid.
- Input path: 2-flop synchroniser (s1, s2), then a previous-value flop s3.
  - rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
  - An event sets its STATUS bit at the next edge. Pin-to-STATUS latency is 3 edges.
- W1C and event on the same bit in the same cycle: the event wins and the bit stays 1.
- Clearing RISE_EN/FALL_EN does not clear STATUS.
- irq = |(STATUS), registered; it follows STATUS with 1 cycle latency.
- Reset asserted mid-access: the access is lost, read_valid stays 0 and all state returns to reset values immediately.
- Enabling an edge while the pin is static produces no event, because s2==s3.

Test Plan:
1. Reset, then write 0x00A5A5A5 to DDR0 and 0x00FFFFFF to DATA0, then read DDR0. Required: read_valid 1 cycle after the strobe, data 0x00A5A5A5; pin_oe[23:0]=0xA5A5A5 and pin_out[23:0]=0xFFFFFF one cycle after the writes.
2. Write OD0=0x000001 and DATA0 bit0=0, then bit0=1. Required: pin_out[0]=0 throughout; pin_oe[0] 1 then 0, regardless of DDR0.
3. Write RISE_EN1=0x000010 and drive pin_in[28] 0->1. Required: STATUS1=0x000010 three edges later and irq=1 one cycle after that. Write 0x10 to STATUS1: STATUS1=0 and irq falls.
4. A rising edge on pin 28 arrives the same cycle as a W1C of that bit. Required: STATUS1 bit4 stays 1 and irq stays 1.
5. NumPins=72: write 0xFFFFFFFF to DATA2, then read DATA2, DDR2 and an unmapped offset +0x700. Required: DATA2 reads sync inputs in [23:0] with [31:24]=0; DDR2 reads 0; +0x700 reads 0 with read_valid.
6. Assert reset_in one cycle after a read strobe with DDR0 set. Required: read_valid never pulses; pin_oe, irq and STATUS are 0 immediately; post-reset reads return 0.
